// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM: fetch/decode/execute/mem/writeback.
// Moore outputs from state; pcen and R-type alucontrol also use inputs.
module mips_mc_ctrl #(
  parameter int OPW = 6,
  parameter int FNW = 6
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [OPW-1:0] op,
  input  logic [FNW-1:0] funct,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           mem_req,
  output logic           memwrite,
  output logic           iord,
  output logic           irwrite,
  output logic           regdst,
  output logic           memtoreg,
  output logic           regwrite,
  output logic           alusrca,
  output logic [1:0]     alusrcb,
  output logic [1:0]     pcsrc,
  output logic           pcen,
  output logic [2:0]     alucontrol,
  output logic           illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD,
    S_MEMWB, S_MEMWR, S_RTYPEEX, S_RTYPEWB,
    S_BEQEX, S_ADDIEX, S_ADDIWB, S_JEX
  } state_t;

  localparam logic [OPW-1:0] OP_LW   = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW   = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_R    = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_J    = OPW'(6'b000010);

  state_t state;
  logic   fn_ok;
  logic [2:0] fn_alu;
  logic   is_mem, is_r, is_beq, is_addi, is_j, legal;
  logic   pcwrite, branch;

  always_comb begin
    fn_ok  = 1'b1;
    fn_alu = 3'b010;
    case (funct)
      FNW'(6'b100000): fn_alu = 3'b010;
      FNW'(6'b100010): fn_alu = 3'b110;
      FNW'(6'b100100): fn_alu = 3'b000;
      FNW'(6'b100101): fn_alu = 3'b001;
      FNW'(6'b101010): fn_alu = 3'b111;
      default:         fn_ok  = 1'b0;
    endcase
  end

  assign is_mem  = (op == OP_LW) || (op == OP_SW);
  assign is_r    = (op == OP_R) && fn_ok;
  assign is_beq  = (op == OP_BEQ);
  assign is_addi = (op == OP_ADDI);
  assign is_j    = (op == OP_J);
  assign legal   = is_mem | is_r | is_beq | is_addi | is_j;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:   if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          unique case (1'b1)
            is_mem:  state <= S_MEMADR;
            is_r:    state <= S_RTYPEEX;
            is_beq:  state <= S_BEQEX;
            is_addi: state <= S_ADDIEX;
            is_j:    state <= S_JEX;
            default: state <= S_FETCH;
          endcase
        end
        S_MEMADR:  state <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:   if (mem_ready) state <= S_MEMWB;
        S_MEMWR:   if (mem_ready) state <= S_FETCH;
        S_RTYPEEX: state <= S_RTYPEWB;
        S_ADDIEX:  state <= S_ADDIWB;
        default:   state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = 3'b000;
    illegal_op = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alusrcb    = 2'b01;
        alucontrol = 3'b010;
        irwrite    = mem_ready;
        pcwrite    = mem_ready;
      end
      S_DECODE: begin
        alusrcb    = 2'b11;
        alucontrol = 3'b010;
        illegal_op = !legal;
      end
      S_MEMADR, S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = 3'b010;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca    = 1'b1;
        alucontrol = fn_alu;
      end
      S_RTYPEWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      S_BEQEX: begin
        alusrca    = 1'b1;
        alucontrol = 3'b110;
        pcsrc      = 2'b01;
        branch     = 1'b1;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
    pcen = pcwrite | (branch & zero);
  end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: per-cycle control vectors.
// Vector: req,mw,iord,irw,rdst,m2r,rw,srca,srcb[2],pcsrc[2],pcen,alu[3],ill.
module tb_mips_mc_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, memwrite, iord, irwrite;
  logic       regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic       pcen, illegal_op;
  logic [2:0] alucontrol;
  logic [16:0] ctl;
  int total = 0;
  int bad = 0;

  localparam logic [16:0] F1   = 17'b10010000_01_00_1_010_0;
  localparam logic [16:0] F0   = 17'b10000000_01_00_0_010_0;
  localparam logic [16:0] DEC  = 17'b00000000_11_00_0_010_0;
  localparam logic [16:0] DILL = 17'b00000000_11_00_0_010_1;
  localparam logic [16:0] MADR = 17'b00000001_10_00_0_010_0;
  localparam logic [16:0] MRD  = 17'b10100000_00_00_0_000_0;
  localparam logic [16:0] MWB  = 17'b00000110_00_00_0_000_0;
  localparam logic [16:0] MWR  = 17'b11100000_00_00_0_000_0;
  localparam logic [16:0] RADD = 17'b00000001_00_00_0_010_0;
  localparam logic [16:0] RSLT = 17'b00000001_00_00_0_111_0;
  localparam logic [16:0] RWB  = 17'b00001010_00_00_0_000_0;
  localparam logic [16:0] BEQ1 = 17'b00000001_00_01_1_110_0;
  localparam logic [16:0] BEQ0 = 17'b00000001_00_01_0_110_0;
  localparam logic [16:0] AWB  = 17'b00000010_00_00_0_000_0;
  localparam logic [16:0] JEX  = 17'b00000000_00_10_1_000_0;

  always #5 clk = ~clk;

  assign ctl = {mem_req, memwrite, iord, irwrite, regdst, memtoreg,
                regwrite, alusrca, alusrcb, pcsrc, pcen, alucontrol,
                illegal_op};

  mips_mc_ctrl dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req),
    .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .pcen(pcen), .alucontrol(alucontrol), .illegal_op(illegal_op)
  );

  task automatic test_reset();
    logic [16:0] e [4];
    e = '{F1, DEC, MADR, MWR};
    mem_ready = 1'b0;
    #1;
    total++;
    if (ctl !== F0) begin
      bad++;
      $display("FAIL reset_state got=%b exp=%b", ctl, F0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    op = 6'b101011;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 0);
      #1;
      total++;
      if (ctl !== e[i]) begin
        bad++;
        $display("FAIL rst_sw c%0d got=%b exp=%b", i, ctl, e[i]);
      end
      if (i < 3) begin
        @(posedge clk); #1;
      end
    end
    #1 reset_n = 1'b0;
    #1;
    total++;
    if (ctl !== F0) begin
      bad++;
      $display("FAIL rst_mid_memwr got=%b exp=%b", ctl, F0);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    total++;
    if (ctl !== F1) begin
      bad++;
      $display("FAIL rst_release got=%b exp=%b", ctl, F1);
    end
    mem_ready = 1'b0;
    #1 reset_n = 1'b0;
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_rtype(input logic [5:0] fn, input logic [16:0] ex);
    logic [16:0] e [5];
    e = '{F1, DEC, ex, RWB, F0};
    op = 6'b000000;
    funct = fn;
    for (int i = 0; i < 5; i++) begin
      mem_ready = (i < 4);
      #1;
      total++;
      if (ctl !== e[i]) begin
        bad++;
        $display("FAIL rtype_%b c%0d got=%b exp=%b", fn, i, ctl, e[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw_wait();
    logic [16:0] e [8];
    logic        r [8];
    e = '{F1, DEC, MADR, MRD, MRD, MRD, MWB, F0};
    r = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    op = 6'b100011;
    for (int i = 0; i < 8; i++) begin
      mem_ready = r[i];
      #1;
      total++;
      if (ctl !== e[i]) begin
        bad++;
        $display("FAIL lw_wait c%0d got=%b exp=%b", i, ctl, e[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_beq();
    logic [16:0] e [7];
    logic        z [7];
    e = '{F1, DEC, BEQ1, F1, DEC, BEQ0, F0};
    z = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    op = 6'b000100;
    for (int i = 0; i < 7; i++) begin
      mem_ready = (i < 6);
      zero = z[i];
      #1;
      total++;
      if (ctl !== e[i]) begin
        bad++;
        $display("FAIL beq c%0d got=%b exp=%b", i, ctl, e[i]);
      end
      @(posedge clk); #1;
    end
    zero = 1'b0;
  endtask

  task automatic test_illegal(input logic [5:0] o, input logic [5:0] fn);
    logic [16:0] e [3];
    e = '{F1, DILL, F0};
    op = o;
    funct = fn;
    for (int i = 0; i < 3; i++) begin
      mem_ready = (i < 2);
      #1;
      total++;
      if (ctl !== e[i]) begin
        bad++;
        $display("FAIL illegal_%b_%b c%0d got=%b exp=%b",
                 o, fn, i, ctl, e[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] e [8];
    e = '{F1, DEC, MADR, MWR, F1, DEC, JEX, F0};
    for (int i = 0; i < 8; i++) begin
      op = (i < 4) ? 6'b101011 : 6'b000010;
      mem_ready = (i < 7);
      #1;
      total++;
      if (ctl !== e[i]) begin
        bad++;
        $display("FAIL sw_j c%0d got=%b exp=%b", i, ctl, e[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_addi();
    logic [16:0] e [5];
    e = '{F1, DEC, MADR, AWB, F0};
    op = 6'b001000;
    for (int i = 0; i < 5; i++) begin
      mem_ready = (i < 4);
      #1;
      total++;
      if (ctl !== e[i]) begin
        bad++;
        $display("FAIL addi c%0d got=%b exp=%b", i, ctl, e[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_rtype(6'b100000, RADD);
    test_rtype(6'b101010, RSLT);
    test_lw_wait();
    test_beq();
    test_illegal(6'b111111, 6'b100000);
    test_illegal(6'b000000, 6'b000111);
    test_back_to_back();
    test_addi();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
